// File: rtl/nor_bus_pg.sv
// NOR flash bus controller: pipelined Wishbone slave to a parallel NOR device.
// A single request slot buffers one access. Reads in the same page keep CE#/OE#
// low and use the shorter page wait. Writes wait for RY/BY# and give up with
// wb_err_o after RY_TIMEOUT.
module nor_bus_pg #(
   parameter int unsigned ADDRBITS    = 26,
   parameter int unsigned DATABITS    = 16,
   parameter int unsigned PAGEBITS    = 3,
   parameter int unsigned COUNTERBITS = 8,
   parameter int unsigned READ_WAIT   = 40,
   parameter int unsigned PAGE_WAIT   = 6,
   parameter int unsigned WRITE_WAIT  = 8,
   parameter int unsigned END_WAIT    = 1,
   parameter int unsigned RY_TIMEOUT  = 255
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic [ADDRBITS-1:0] wb_adr_i,
   input  logic [DATABITS-1:0] wb_dat_i,
   input  logic                wb_we_i,
   input  logic                wb_stb_i,
   input  logic                wb_cyc_i,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic [DATABITS-1:0] wb_dat_o,
   output logic                wb_stall_o,
   input  logic                nor_ry_i,
   input  logic [DATABITS-1:0] nor_data_i,
   output logic [DATABITS-1:0] nor_data_o,
   output logic [ADDRBITS-1:0] nor_addr_o,
   output logic                nor_ce_o,
   output logic                nor_we_o,
   output logic                nor_oe_o,
   output logic                nor_data_oe
);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StReadPg,
      StRyWait,
      StWrite,
      StEnd
   } state_e;

   localparam logic [COUNTERBITS-1:0] ReadWaitC  = COUNTERBITS'(READ_WAIT);
   localparam logic [COUNTERBITS-1:0] PageWaitC  = COUNTERBITS'(PAGE_WAIT);
   localparam logic [COUNTERBITS-1:0] WriteWaitC = COUNTERBITS'(WRITE_WAIT);
   localparam logic [COUNTERBITS-1:0] EndWaitC   = COUNTERBITS'(END_WAIT);
   localparam logic [COUNTERBITS-1:0] RyTimeoutC = COUNTERBITS'(RY_TIMEOUT);

   state_e                 state_q;
   logic [COUNTERBITS-1:0] cnt_q;

   // Request slot
   logic                   slot_valid_q;
   logic                   slot_we_q;
   logic [DATABITS-1:0]    slot_dat_q;
   logic [ADDRBITS-1:0]    slot_adr_q;

   // Registered outputs
   logic                   ack_q;
   logic                   err_q;
   logic [DATABITS-1:0]    rdat_q;
   logic [DATABITS-1:0]    nor_data_q;
   logic [ADDRBITS-1:0]    nor_addr_q;
   logic                   ce_q;
   logic                   we_q;
   logic                   oe_q;
   logic                   data_oe_q;

   logic slot_load;
   logic abort;
   logic page_hit;
   logic read_done;

   // Slot acceptance, abort detection and page-hit decode
   always_comb begin
      slot_load = wb_cyc_i & wb_stb_i & ~slot_valid_q;
      // END is excluded so a bus that stays idle with cyc low still returns to IDLE
      abort     = ~wb_cyc_i & (state_q != StIdle) & (state_q != StEnd);
      page_hit  = slot_valid_q & ~slot_we_q &
                  (slot_adr_q[ADDRBITS-1:PAGEBITS] == nor_addr_q[ADDRBITS-1:PAGEBITS]);
      read_done = ((state_q == StRead)   && (cnt_q == ReadWaitC)) ||
                  ((state_q == StReadPg) && (cnt_q == PageWaitC));
   end

   // Controller state machine, request slot and all registered outputs
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         slot_valid_q <= 1'b0;
         slot_we_q    <= 1'b0;
         slot_dat_q   <= '0;
         slot_adr_q   <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         rdat_q       <= '0;
         nor_data_q   <= '0;
         nor_addr_q   <= '0;
         ce_q         <= 1'b1;
         we_q         <= 1'b1;
         oe_q         <= 1'b1;
         data_oe_q    <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         cnt_q <= cnt_q + 1'b1;

         if (slot_load) begin
            slot_valid_q <= 1'b1;
            slot_we_q    <= wb_we_i;
            slot_dat_q   <= wb_dat_i;
            slot_adr_q   <= wb_adr_i;
         end

         if (abort) begin
            slot_valid_q <= 1'b0;
            state_q      <= StEnd;
            cnt_q        <= '0;
            ce_q         <= 1'b1;
            we_q         <= 1'b1;
            oe_q         <= 1'b1;
            data_oe_q    <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (slot_valid_q) begin
                     slot_valid_q <= 1'b0;
                     cnt_q        <= '0;
                     nor_addr_q   <= slot_adr_q;
                     nor_data_q   <= slot_dat_q;
                     if (!slot_we_q) begin
                        ce_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        state_q <= StRead;
                     end else if (nor_ry_i) begin
                        ce_q      <= 1'b0;
                        we_q      <= 1'b0;
                        data_oe_q <= 1'b1;
                        state_q   <= StWrite;
                     end else begin
                        state_q <= StRyWait;
                     end
                  end
               end

               StRyWait: begin
                  if (nor_ry_i) begin
                     ce_q      <= 1'b0;
                     we_q      <= 1'b0;
                     data_oe_q <= 1'b1;
                     cnt_q     <= '0;
                     state_q   <= StWrite;
                  end else if (cnt_q == RyTimeoutC) begin
                     err_q   <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= StEnd;
                  end
               end

               StWrite: begin
                  if (cnt_q == WriteWaitC) begin
                     ack_q     <= 1'b1;
                     ce_q      <= 1'b1;
                     we_q      <= 1'b1;
                     data_oe_q <= 1'b0;
                     cnt_q     <= '0;
                     state_q   <= StEnd;
                  end
               end

               StRead, StReadPg: begin
                  if (read_done) begin
                     rdat_q <= nor_data_i;
                     ack_q  <= 1'b1;
                     cnt_q  <= '0;
                     if (page_hit) begin
                        // Same page: keep CE#/OE# low, only the address moves
                        slot_valid_q <= 1'b0;
                        nor_addr_q   <= slot_adr_q;
                        state_q      <= StReadPg;
                     end else begin
                        ce_q    <= 1'b1;
                        oe_q    <= 1'b1;
                        state_q <= StEnd;
                     end
                  end
               end

               StEnd: begin
                  ce_q      <= 1'b1;
                  we_q      <= 1'b1;
                  oe_q      <= 1'b1;
                  data_oe_q <= 1'b0;
                  if (cnt_q == EndWaitC) begin
                     state_q <= StIdle;
                  end
               end

               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign wb_ack_o    = ack_q;
   assign wb_err_o    = err_q;
   assign wb_dat_o    = rdat_q;
   assign wb_stall_o  = slot_valid_q;
   assign nor_data_o  = nor_data_q;
   assign nor_addr_o  = nor_addr_q;
   assign nor_ce_o    = ce_q;
   assign nor_we_o    = we_q;
   assign nor_oe_o    = oe_q;
   assign nor_data_oe = data_oe_q;

endmodule

// File: tb/tb_nor_bus_pg.sv
// Directed bench for nor_bus_pg with default parameters. The NOR device is
// modelled as read data = low address bits XOR 16'hA5C3.
module tb_nor_bus_pg;

   logic        clk;
   logic        rst_n;
   logic [25:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic [15:0] wb_dat_o;
   logic        wb_stall_o;
   logic        nor_ry_i;
   logic [15:0] nor_data_i;
   logic [15:0] nor_data_o;
   logic [25:0] nor_addr_o;
   logic        nor_ce_o;
   logic        nor_we_o;
   logic        nor_oe_o;
   logic        nor_data_oe;

   int nchk = 0;
   int nerr = 0;
   int t = 0;

   // Monitor records (append-only, tests use deltas)
   int          ack_t[$];
   logic [15:0] ack_d[$];
   int          err_t[$];
   int          we_t[$];
   int          ce_low = 0;
   int          oe_low = 0;
   int          doe_hi = 0;
   int          doe_bad = 0;
   int          both = 0;

   nor_bus_pg dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wb_adr_i    (wb_adr_i),
      .wb_dat_i    (wb_dat_i),
      .wb_we_i     (wb_we_i),
      .wb_stb_i    (wb_stb_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_ack_o    (wb_ack_o),
      .wb_err_o    (wb_err_o),
      .wb_dat_o    (wb_dat_o),
      .wb_stall_o  (wb_stall_o),
      .nor_ry_i    (nor_ry_i),
      .nor_data_i  (nor_data_i),
      .nor_data_o  (nor_data_o),
      .nor_addr_o  (nor_addr_o),
      .nor_ce_o    (nor_ce_o),
      .nor_we_o    (nor_we_o),
      .nor_oe_o    (nor_oe_o),
      .nor_data_oe (nor_data_oe)
   );

   assign nor_data_i = nor_addr_o[15:0] ^ 16'hA5C3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) t <= t + 1;

   always @(negedge clk) begin
      if (wb_ack_o) begin
         ack_t.push_back(t);
         ack_d.push_back(wb_dat_o);
      end
      if (wb_err_o) err_t.push_back(t);
      if (wb_ack_o && wb_err_o) both++;
      if (!nor_ce_o) ce_low++;
      if (!nor_oe_o) oe_low++;
      if (!nor_we_o) we_t.push_back(t);
      if (nor_data_oe) doe_hi++;
      if (nor_data_oe !== !nor_we_o) doe_bad++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a request and hold it until accepted; acc = index of the accept edge
   task automatic req(input logic we, input logic [25:0] adr, input logic [15:0] dat,
                      output int acc);
      logic s;
      int   k;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_stb_i = 1'b1;
      k = 0;
      do begin
         s = wb_stall_o;
         tick(1);
         k++;
      end while (s && k < 500);
      acc = t;
      check("req_accepted", 32'(s), 32'd0);
   endtask

   int a, a2, b_ack, b_err, b_we, b_ce, b_oe, b_doe;

   task automatic snap();
      b_ack = ack_t.size();
      b_err = err_t.size();
      b_we  = we_t.size();
      b_ce  = ce_low;
      b_oe  = oe_low;
      b_doe = doe_hi;
   endtask

   initial begin
      rst_n    = 1'b0;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_we_i  = 1'b0;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      nor_ry_i = 1'b1;
      tick(3);

      // Reset values
      check("rst_ack", 32'(wb_ack_o), 32'd0);
      check("rst_err", 32'(wb_err_o), 32'd0);
      check("rst_stall", 32'(wb_stall_o), 32'd0);
      check("rst_dat", 32'(wb_dat_o), 32'd0);
      check("rst_ndat", 32'(nor_data_o), 32'd0);
      check("rst_addr", 32'(nor_addr_o), 32'd0);
      check("rst_ce", 32'(nor_ce_o), 32'd1);
      check("rst_we", 32'(nor_we_o), 32'd1);
      check("rst_oe", 32'(nor_oe_o), 32'd1);
      check("rst_doe", 32'(nor_data_oe), 32'd0);
      rst_n = 1'b1;
      wb_cyc_i = 1'b1;
      tick(2);

      // Single random read
      snap();
      req(1'b0, 26'h100, 16'h0, a);
      wb_stb_i = 1'b0;
      tick(45);
      check("rd1_nack", 32'(ack_t.size() - b_ack), 32'd1);
      check("rd1_lat", 32'(ack_t[b_ack] - a), 32'd42);
      check("rd1_data", 32'(ack_d[b_ack]), 32'hA4C3);
      check("rd1_ce_low", 32'(ce_low - b_ce), 32'd41);
      check("rd1_oe_low", 32'(oe_low - b_oe), 32'd41);

      // Pipelined same-page reads
      snap();
      req(1'b0, 26'h100, 16'h0, a);
      req(1'b0, 26'h101, 16'h0, a2);
      req(1'b0, 26'h102, 16'h0, a2);
      req(1'b0, 26'h103, 16'h0, a2);
      wb_stb_i = 1'b0;
      tick(70 - (t - a));
      check("pg_nack", 32'(ack_t.size() - b_ack), 32'd4);
      check("pg_lat0", 32'(ack_t[b_ack] - a), 32'd42);
      check("pg_lat1", 32'(ack_t[b_ack+1] - a), 32'd49);
      check("pg_lat2", 32'(ack_t[b_ack+2] - a), 32'd56);
      check("pg_lat3", 32'(ack_t[b_ack+3] - a), 32'd63);
      check("pg_d0", 32'(ack_d[b_ack]), 32'hA4C3);
      check("pg_d1", 32'(ack_d[b_ack+1]), 32'hA4C2);
      check("pg_d2", 32'(ack_d[b_ack+2]), 32'hA4C1);
      check("pg_d3", 32'(ack_d[b_ack+3]), 32'hA4C0);
      check("pg_ce_low", 32'(ce_low - b_ce), 32'd62);
      check("pg_addr", 32'(nor_addr_o), 32'h103);

      // Page boundary: second read takes the miss path
      snap();
      req(1'b0, 26'h107, 16'h0, a);
      req(1'b0, 26'h108, 16'h0, a2);
      wb_stb_i = 1'b0;
      tick(100 - (t - a));
      check("pb_nack", 32'(ack_t.size() - b_ack), 32'd2);
      check("pb_lat0", 32'(ack_t[b_ack] - a), 32'd42);
      check("pb_gap", 32'(ack_t[b_ack+1] - ack_t[b_ack]), 32'd44);
      check("pb_d0", 32'(ack_d[b_ack]), 32'hA4C4);
      check("pb_d1", 32'(ack_d[b_ack+1]), 32'hA4CB);
      check("pb_ce_low", 32'(ce_low - b_ce), 32'd82);

      // Write delayed by RY/BY# low for 10 cycles
      snap();
      nor_ry_i = 1'b0;
      req(1'b1, 26'h20, 16'h1234, a);
      wb_stb_i = 1'b0;
      tick(10);
      nor_ry_i = 1'b1;
      tick(20);
      check("wr_nack", 32'(ack_t.size() - b_ack), 32'd1);
      check("wr_lat", 32'(ack_t[b_ack] - a), 32'd20);
      check("wr_we_low", 32'(we_t.size() - b_we), 32'd9);
      check("wr_we_first", 32'(we_t[b_we] - a), 32'd11);
      check("wr_doe_hi", 32'(doe_hi - b_doe), 32'd9);
      check("wr_doe_track", 32'(doe_bad), 32'd0);
      check("wr_pad_data", 32'(nor_data_o), 32'h1234);
      check("wr_pad_addr", 32'(nor_addr_o), 32'h20);
      check("wr_nerr", 32'(err_t.size() - b_err), 32'd0);

      // RY/BY# stuck low: timeout error, no write strobe
      snap();
      nor_ry_i = 1'b0;
      req(1'b1, 26'h30, 16'hBEEF, a);
      wb_stb_i = 1'b0;
      tick(262);
      nor_ry_i = 1'b1;
      check("to_nerr", 32'(err_t.size() - b_err), 32'd1);
      check("to_lat", 32'(err_t[b_err] - a), 32'd257);
      check("to_nack", 32'(ack_t.size() - b_ack), 32'd0);
      check("to_we_low", 32'(we_t.size() - b_we), 32'd0);
      snap();
      req(1'b0, 26'h200, 16'h0, a);
      wb_stb_i = 1'b0;
      tick(45);
      check("to_rd_lat", 32'(ack_t[b_ack] - a), 32'd42);
      check("to_rd_data", 32'(ack_d[b_ack]), 32'hA7C3);

      // Cycle drop mid-READ with a request still queued
      snap();
      req(1'b0, 26'h100, 16'h0, a);
      req(1'b0, 26'h101, 16'h0, a2);
      wb_stb_i = 1'b0;
      tick(15);
      wb_cyc_i = 1'b0;
      tick(1);
      check("ab_ce", 32'(nor_ce_o), 32'd1);
      check("ab_oe", 32'(nor_oe_o), 32'd1);
      check("ab_stall", 32'(wb_stall_o), 32'd0);
      tick(3);
      wb_cyc_i = 1'b1;
      tick(50);
      check("ab_nack", 32'(ack_t.size() - b_ack), 32'd0);
      req(1'b0, 26'h102, 16'h0, a);
      wb_stb_i = 1'b0;
      tick(45);
      check("ab_rd_nack", 32'(ack_t.size() - b_ack), 32'd1);
      check("ab_rd_lat", 32'(ack_t[b_ack] - a), 32'd42);
      check("ab_rd_data", 32'(ack_d[b_ack]), 32'hA4C1);

      // Asynchronous reset mid-READPG
      snap();
      req(1'b0, 26'h100, 16'h0, a);
      req(1'b0, 26'h101, 16'h0, a2);
      wb_stb_i = 1'b0;
      tick(45 - (t - a));
      rst_n = 1'b0;
      #1;
      check("rs_ce", 32'(nor_ce_o), 32'd1);
      check("rs_oe", 32'(nor_oe_o), 32'd1);
      check("rs_stall", 32'(wb_stall_o), 32'd0);
      check("rs_addr", 32'(nor_addr_o), 32'd0);
      check("rs_ack", 32'(wb_ack_o), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(20);
      check("rs_nack", 32'(ack_t.size() - b_ack), 32'd1);
      check("rs_d0", 32'(ack_d[b_ack]), 32'hA4C3);
      req(1'b0, 26'h103, 16'h0, a);
      wb_stb_i = 1'b0;
      tick(45);
      check("rs_rd_nack", 32'(ack_t.size() - b_ack), 32'd2);
      check("rs_rd_lat", 32'(ack_t[b_ack+1] - a), 32'd42);
      check("rs_rd_data", 32'(ack_d[b_ack+1]), 32'hA4C0);

      check("ack_err_excl", 32'(both), 32'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
